// File: rtl/mtr_pwm_drv.sv
// mtr_pwm_drv -- dual-channel H-bridge PWM driver.
//
// Turns the signed 12-bit wheel commands into fwd/rev PWM pairs for two
// motor bridges. Both channels share one free-running 11-bit timebase whose
// period is 2048 clks. Commands are sampled only on the last cycle of a
// period (cnt == 2047) and take effect from the next cnt == 0.
//
// Per channel the command is saturated, floored at MIN_DUTY, and passed
// through a small OFF/FWD/REV/DEAD state machine. A direction reversal with
// a nonzero target always goes through DEAD_PERIODS whole periods with both
// bridge outputs low.
//
// Optional feature macro: MTR_PWM_SLEW_EN
//   When defined, the applied duty moves toward the target by at most
//   SLEW_STEP per period. Every entry into a drive state from OFF or DEAD
//   ramps up from 0.
//
// Parameters:
//   DEAD_PERIODS  whole periods of dead time on a reversal (1..15)
//   MIN_DUTY      magnitudes below this are driven as 0 duty
//   SLEW_STEP     maximum applied-duty change per period (slew builds only)
//
// Ports:
//   clk           system clock
//   rst           synchronous active-high reset
//   en            drive enable; low forces every PWM output low on the next clk
//   lft_spd       signed left wheel command
//   rght_spd      signed right wheel command
//   lft_fwd_pwm   left bridge forward PWM   (registered)
//   lft_rev_pwm   left bridge reverse PWM   (registered)
//   rght_fwd_pwm  right bridge forward PWM  (registered)
//   rght_rev_pwm  right bridge reverse PWM  (registered)
//   pwm_synch     one-clk pulse on the first cycle of each PWM period
module mtr_pwm_drv #(
  parameter int unsigned DEAD_PERIODS = 1,
  parameter logic [10:0] MIN_DUTY     = 11'h010,
  parameter logic [10:0] SLEW_STEP    = 11'h040
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [11:0] lft_spd,
  input  logic [11:0] rght_spd,
  output logic        lft_fwd_pwm,
  output logic        lft_rev_pwm,
  output logic        rght_fwd_pwm,
  output logic        rght_rev_pwm,
  output logic        pwm_synch
);

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_FWD  = 2'd1,
    ST_REV  = 2'd2,
    ST_DEAD = 2'd3
  } state_t;

  localparam logic [3:0] DEAD_LAST = 4'(DEAD_PERIODS - 1);

  // Shared timebase. period_end marks the sampling cycle; everything decided
  // on it becomes visible from the following cnt == 0.
  logic [10:0] cnt;
  logic [10:0] cnt_nxt;
  logic        period_end;

  assign cnt_nxt    = cnt + 11'd1;
  assign period_end = (cnt == 11'h7FF);

  // Channel 0 = left, channel 1 = right.
  logic [11:0] spd       [2];
  state_t      st        [2];
  state_t      st_nxt    [2];
  logic [10:0] duty      [2];
  logic [10:0] duty_nxt  [2];
  logic        dir       [2];  // 0 = forward, 1 = reverse; pending dir while DEAD
  logic        dir_nxt   [2];
  logic [3:0]  dead_cnt  [2];  // DEAD periods still to go after the current one
  logic [3:0]  dead_nxt  [2];
  logic [10:0] tmag      [2];
  logic        tdir      [2];

  assign spd[0] = lft_spd;
  assign spd[1] = rght_spd;

  // Saturated, floored magnitude of a signed command. -2048 has no positive
  // 12-bit counterpart, so it clamps to the largest duty.
  function automatic logic [10:0] tgt_mag(input logic [11:0] s);
    logic [11:0] a;
    a = s[11] ? (~s + 12'd1) : s;
    if (a[11])
      return 11'h7FF;
    else if (a[10:0] < MIN_DUTY)
      return 11'd0;
    else
      return a[10:0];
  endfunction

  // One period's worth of duty movement toward the target, clamped at target.
  function automatic logic [10:0] slew(input logic [10:0] cur,
                                       input logic [10:0] tgt);
    if (tgt > cur)
      return ((tgt - cur) > SLEW_STEP) ? (cur + SLEW_STEP) : tgt;
    else
      return ((cur - tgt) > SLEW_STEP) ? (cur - SLEW_STEP) : tgt;
  endfunction

  // Target magnitude and direction. A zero target leaves the direction alone
  // so a floored command never triggers a reversal.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      tmag[i] = tgt_mag(spd[i]);
      tdir[i] = (tmag[i] == 11'd0) ? dir[i] : spd[i][11];
    end
  end

  // Next-state logic for both channels. en low overrides everything and is
  // not tied to the period boundary; leaving OFF is.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      st_nxt[i]   = st[i];
      duty_nxt[i] = duty[i];
      dir_nxt[i]  = dir[i];
      dead_nxt[i] = dead_cnt[i];
      if (!en) begin
        st_nxt[i]   = ST_OFF;
        duty_nxt[i] = 11'd0;
        dead_nxt[i] = 4'd0;
      end else if (period_end) begin
        case (st[i])
          ST_OFF: begin
            st_nxt[i]  = tdir[i] ? ST_REV : ST_FWD;
            dir_nxt[i] = tdir[i];
`ifdef MTR_PWM_SLEW_EN
            duty_nxt[i] = slew(11'd0, tmag[i]);
`else
            duty_nxt[i] = tmag[i];
`endif
          end
          ST_FWD, ST_REV: begin
            if (tdir[i] != dir[i]) begin
              st_nxt[i]   = ST_DEAD;
              dir_nxt[i]  = tdir[i];
              duty_nxt[i] = 11'd0;
              dead_nxt[i] = DEAD_LAST;
            end else begin
`ifdef MTR_PWM_SLEW_EN
              duty_nxt[i] = slew(duty[i], tmag[i]);
`else
              duty_nxt[i] = tmag[i];
`endif
            end
          end
          default: begin  // ST_DEAD: the pending direction was latched on entry
            if (dead_cnt[i] == 4'd0) begin
              st_nxt[i] = dir[i] ? ST_REV : ST_FWD;
`ifdef MTR_PWM_SLEW_EN
              duty_nxt[i] = slew(11'd0, tmag[i]);
`else
              duty_nxt[i] = tmag[i];
`endif
            end else begin
              dead_nxt[i] = dead_cnt[i] - 4'd1;
            end
          end
        endcase
      end
    end
  end

  // Outputs are registered from next-cycle values so the first high cycle of
  // a period lines up with pwm_synch. The per-channel state allows only one
  // direction at a time, so fwd and rev can never both be high.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt          <= 11'd0;
      pwm_synch    <= 1'b0;
      lft_fwd_pwm  <= 1'b0;
      lft_rev_pwm  <= 1'b0;
      rght_fwd_pwm <= 1'b0;
      rght_rev_pwm <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        st[i]       <= ST_OFF;
        duty[i]     <= 11'd0;
        dir[i]      <= 1'b0;
        dead_cnt[i] <= 4'd0;
      end
    end else begin
      cnt          <= cnt_nxt;
      pwm_synch    <= period_end;
      lft_fwd_pwm  <= (st_nxt[0] == ST_FWD) && (cnt_nxt < duty_nxt[0]);
      lft_rev_pwm  <= (st_nxt[0] == ST_REV) && (cnt_nxt < duty_nxt[0]);
      rght_fwd_pwm <= (st_nxt[1] == ST_FWD) && (cnt_nxt < duty_nxt[1]);
      rght_rev_pwm <= (st_nxt[1] == ST_REV) && (cnt_nxt < duty_nxt[1]);
      for (int i = 0; i < 2; i++) begin
        st[i]       <= st_nxt[i];
        duty[i]     <= duty_nxt[i];
        dir[i]      <= dir_nxt[i];
        dead_cnt[i] <= dead_nxt[i];
      end
    end
  end

endmodule
